// File: rtl/tri_bbox_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tri_bbox_scanner
// Purpose  : Clamps a triangle's bounding box to the display and streams it
//            out row-major as LANES-wide pixel beats with valid/ready flow.
// Revision : 1.0 - initial release
// ============================================================================

package tri_bbox_pkg;
  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
  } vertex_t;

  typedef struct packed {
    vertex_t a;
    vertex_t b;
    vertex_t c;
  } tri_t;
endpackage

module tri_bbox_scanner
  import tri_bbox_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 100,
  parameter int DISPLAY_HEIGHT = 100,
  parameter int LANES          = 1,
  localparam int c_XW = (DISPLAY_WIDTH  > 1) ? $clog2(DISPLAY_WIDTH)  : 1,
  localparam int c_YW = (DISPLAY_HEIGHT > 1) ? $clog2(DISPLAY_HEIGHT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  tri_t             in_tri,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [c_XW-1:0]  pix_x,
  output logic [c_YW-1:0]  pix_y,
  output logic [LANES-1:0] pix_mask,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_last,
  output logic             tri_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BOX  = 2'd1,
    SCAN = 2'd2
  } state_t;

  // Extra headroom so pix_x + LANES never wraps before the bound compare.
  localparam int                 c_SW        = c_XW + 5;
  localparam logic [c_SW-1:0]    c_LANES_EXT = c_SW'(LANES);
  localparam logic signed [31:0] c_XMAX      = 32'(DISPLAY_WIDTH - 1);
  localparam logic signed [31:0] c_YMAX      = 32'(DISPLAY_HEIGHT - 1);

  function automatic logic signed [31:0] smin3(input logic signed [31:0] p,
                                               input logic signed [31:0] q,
                                               input logic signed [31:0] r);
    logic signed [31:0] m;
    m = (p < q) ? p : q;
    return (m < r) ? m : r;
  endfunction

  function automatic logic signed [31:0] smax3(input logic signed [31:0] p,
                                               input logic signed [31:0] q,
                                               input logic signed [31:0] r);
    logic signed [31:0] m;
    m = (p > q) ? p : q;
    return (m > r) ? m : r;
  endfunction

  state_t r_state;
  state_t w_state_next;
  tri_t   r_tri;
  logic   r_done;

  logic [c_XW-1:0] r_pix_x;
  logic [c_XW-1:0] r_bx0;
  logic [c_XW-1:0] r_bx1;
  logic [c_YW-1:0] r_pix_y;
  logic [c_YW-1:0] r_by1;

  logic signed [31:0] w_minx, w_maxx, w_miny, w_maxy;
  logic signed [31:0] w_bx0, w_bx1, w_by0, w_by1;
  logic               w_cull;

  logic [c_SW-1:0] w_x_ext;
  logic [c_SW-1:0] w_x_adv;
  logic [c_SW-1:0] w_bx1_ext;
  logic            w_x_fits;
  logic            w_scan;
  logic            w_xfer;
  logic            w_accept;
  logic            w_load;
  logic            w_done_next;

  // Signed bounding box of the captured triangle, clamped to the screen.
  always_comb begin
    w_minx = smin3(r_tri.a.x, r_tri.b.x, r_tri.c.x);
    w_maxx = smax3(r_tri.a.x, r_tri.b.x, r_tri.c.x);
    w_miny = smin3(r_tri.a.y, r_tri.b.y, r_tri.c.y);
    w_maxy = smax3(r_tri.a.y, r_tri.b.y, r_tri.c.y);
    w_bx0  = (w_minx > 32'sd0)  ? w_minx : 32'sd0;
    w_bx1  = (w_maxx < c_XMAX)  ? w_maxx : c_XMAX;
    w_by0  = (w_miny > 32'sd0)  ? w_miny : 32'sd0;
    w_by1  = (w_maxy < c_YMAX)  ? w_maxy : c_YMAX;
    w_cull = (w_bx0 > w_bx1) || (w_by0 > w_by1);
  end

  assign w_scan    = (r_state == SCAN);
  assign w_xfer    = w_scan && pix_ready;
  assign w_x_ext   = {5'd0, r_pix_x};
  assign w_bx1_ext = {5'd0, r_bx1};
  assign w_x_adv   = w_x_ext + c_LANES_EXT;
  assign w_x_fits  = (w_x_adv <= w_bx1_ext);

  assign in_ready  = (r_state == IDLE);
  assign pix_valid = w_scan;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign pix_last  = w_scan && !w_x_fits && (r_pix_y == r_by1);
  assign tri_done  = r_done;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_mask
      assign pix_mask[gi] = w_scan && ((w_x_ext + c_SW'(gi)) <= w_bx1_ext);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = BOX;
        end
      end
      BOX: begin
        if (w_cull) begin
          w_done_next  = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_load       = 1'b1;
          w_state_next = SCAN;
        end
      end
      SCAN: begin
        if (w_xfer && pix_last) begin
          w_done_next  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Once culling is ruled out the clamped bounds are non-negative and inside
  // the display, so truncating them to pixel-coordinate width is lossless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tri   <= '0;
      r_pix_x <= '0;
      r_pix_y <= '0;
      r_bx0   <= '0;
      r_bx1   <= '0;
      r_by1   <= '0;
    end else begin
      if (w_accept) begin
        r_tri <= in_tri;
      end
      if (w_load) begin
        r_bx0   <= w_bx0[c_XW-1:0];
        r_bx1   <= w_bx1[c_XW-1:0];
        r_by1   <= w_by1[c_YW-1:0];
        r_pix_x <= w_bx0[c_XW-1:0];
        r_pix_y <= w_by0[c_YW-1:0];
      end else if (w_xfer && !pix_last) begin
        if (w_x_fits) begin
          r_pix_x <= w_x_adv[c_XW-1:0];
        end else begin
          r_pix_x <= r_bx0;
          r_pix_y <= r_pix_y + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tri_bbox_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_tri_bbox_scanner
// Purpose  : Directed self-checking bench for tri_bbox_scanner (LANES=1 and 4).
// Revision : 1.0 - initial release
// ============================================================================

module tb_tri_bbox_scanner;
  import tri_bbox_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  tri_t in_tri;
  logic in_valid1 = 1'b0, in_valid4 = 1'b0;
  logic pix_ready1 = 1'b1, pix_ready4 = 1'b1;

  logic       in_ready1, pix_valid1, pix_last1, tri_done1;
  logic [6:0] pix_x1, pix_y1;
  logic [0:0] pix_mask1;
  logic       in_ready4, pix_valid4, pix_last4, tri_done4;
  logic [6:0] pix_x4, pix_y4;
  logic [3:0] pix_mask4;

  int n_cmp = 0;
  int n_bad = 0;

  int e4x[4] = '{0, 4, 0, 4};
  int e4y[4] = '{0, 0, 1, 1};
  int e4m[4] = '{15, 3, 15, 3};
  int e4l[4] = '{0, 0, 0, 1};

  always #5 clk = ~clk;

  tri_bbox_scanner #(.DISPLAY_WIDTH(100), .DISPLAY_HEIGHT(100), .LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_tri(in_tri), .in_valid(in_valid1), .in_ready(in_ready1),
    .pix_x(pix_x1), .pix_y(pix_y1), .pix_mask(pix_mask1), .pix_valid(pix_valid1),
    .pix_ready(pix_ready1), .pix_last(pix_last1), .tri_done(tri_done1)
  );

  tri_bbox_scanner #(.DISPLAY_WIDTH(100), .DISPLAY_HEIGHT(100), .LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_tri(in_tri), .in_valid(in_valid4), .in_ready(in_ready4),
    .pix_x(pix_x4), .pix_y(pix_y4), .pix_mask(pix_mask4), .pix_valid(pix_valid4),
    .pix_ready(pix_ready4), .pix_last(pix_last4), .tri_done(tri_done4)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic tri_t mk(input int ax, input int ay, input int bx,
                              input int by, input int cx, input int cy);
    tri_t t;
    t.a.x = ax; t.a.y = ay;
    t.b.x = bx; t.b.y = by;
    t.c.x = cx; t.c.y = cy;
    return t;
  endfunction

  // Presents a triangle for one cycle (cycle N); returns 1ns into cycle N+2.
  task automatic send(input tri_t t, input bit to4);
    @(posedge clk); #1;
    in_tri = t;
    if (to4) in_valid4 = 1'b1; else in_valid1 = 1'b1;
    @(negedge clk);
    chk("accept_rdy", to4 ? in_ready4 : in_ready1, 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    in_valid4 = 1'b0;
    @(negedge clk);
    chk("box_no_beat", to4 ? pix_valid4 : pix_valid1, 0);
    @(posedge clk); #1;
  endtask

  // Consumes the LANES=1 beat stream and compares it to the row-major box.
  task automatic scan1(input string tag, input int x0, input int x1,
                       input int y0, input int y1, input bit rnd);
    int ex, ey, nb, nerr;
    bit held, done;
    logic [6:0] hx, hy;
    logic hl;
    ex = x0; ey = y0; nb = 0; nerr = 0; held = 0; done = 0;
    hx = '0; hy = '0; hl = 1'b0;
    for (int cyc = 0; cyc < 30000 && !done && nerr < 64; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk({tag, "_first_valid"}, pix_valid1, 1);
      if (!pix_valid1 || tri_done1) nerr++;
      if (held && (pix_x1 !== hx || pix_y1 !== hy || pix_last1 !== hl)) nerr++;
      held = 0;
      if (pix_valid1 && pix_ready1) begin
        nb++;
        if (pix_x1 != 7'(ex) || pix_y1 != 7'(ey) || pix_mask1 != 1'b1 ||
            pix_last1 != (ex == x1 && ey == y1)) nerr++;
        if (ex == x1 && ey == y1) done = 1;
        else if (ex < x1) ex++;
        else begin ex = x0; ey++; end
      end else if (pix_valid1) begin
        held = 1; hx = pix_x1; hy = pix_y1; hl = pix_last1;
      end
      @(posedge clk); #1;
      pix_ready1 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    pix_ready1 = 1'b1;
    chk({tag, "_beats"}, nb, (x1 - x0 + 1) * (y1 - y0 + 1));
    chk({tag, "_seq_err"}, nerr, 0);
    @(negedge clk);
    chk({tag, "_done"}, tri_done1, 1);
    chk({tag, "_rdy"}, in_ready1, 1);
    chk({tag, "_idle"}, pix_valid1, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_done_pulse"}, tri_done1, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int nb, quiet_err;
    in_tri = mk(0, 0, 0, 0, 0, 0);
    // in_valid held high through reset must be ignored
    in_valid1 = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    in_valid1 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", pix_valid1, 0);
    chk("rst_last", pix_last1, 0);
    chk("rst_done", tri_done1, 0);
    chk("rst_mask", pix_mask1, 0);
    chk("rst_x", pix_x1, 0);
    chk("rst_y", pix_y1, 0);
    chk("rst_rdy", in_ready1, 1);
    chk("rst_mask4", pix_mask4, 0);
    chk("rst_rdy4", in_ready4, 1);

    send(mk(2, 3, 4, 3, 2, 5), 0);
    scan1("small", 2, 4, 3, 5, 0);

    send(mk(7, 8, 7, 8, 7, 8), 0);
    scan1("point", 7, 7, 8, 8, 0);

    send(mk(0, 0, 5, 0, 0, 1), 1);
    nb = 0;
    for (int cyc = 0; cyc < 20 && nb < 4; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("l4_first_valid", pix_valid4, 1);
      if (pix_valid4) begin
        chk("l4_x", pix_x4, e4x[nb]);
        chk("l4_y", pix_y4, e4y[nb]);
        chk("l4_mask", pix_mask4, e4m[nb]);
        chk("l4_last", pix_last4, e4l[nb]);
        nb++;
      end
      @(posedge clk); #1;
    end
    chk("l4_beats", nb, 4);
    @(negedge clk);
    chk("l4_done", tri_done4, 1);
    chk("l4_idle", pix_valid4, 0);
    @(posedge clk); #1;

    send(mk(150, 10, 160, 20, 170, 30), 0);
    @(negedge clk);
    chk("cull_done", tri_done1, 1);
    chk("cull_valid", pix_valid1, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cull_rdy", in_ready1, 1);
    chk("cull_done_pulse", tri_done1, 0);
    chk("cull_valid2", pix_valid1, 0);
    @(posedge clk); #1;

    send(mk(-10, -10, 200, -5, 50, 300), 0);
    scan1("clamp", 0, 99, 0, 99, 0);

    send(mk(2, 3, 4, 3, 2, 5), 0);
    scan1("stall", 2, 4, 3, 5, 1);

    // Abandon a triangle after its third beat has transferred
    send(mk(2, 3, 4, 3, 2, 5), 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    chk("pre_rst_valid", pix_valid1, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", pix_valid1, 0);
    quiet_err = 0;
    repeat (2) begin
      @(negedge clk);
      if (tri_done1 || pix_valid1) quiet_err++;
    end
    #2;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (tri_done1 || pix_valid1 || !in_ready1) quiet_err++;
    end
    chk("rst_abandon_quiet", quiet_err, 0);

    send(mk(2, 3, 4, 3, 2, 5), 0);
    scan1("after_rst", 2, 4, 3, 5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
